// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 encodings and FSM state type.
package muldiv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> multiply/divide unit bundle; master is the pipeline, slave is the unit.
// The unit answers with a combinational stall and a one-cycle result_valid pulse.
interface muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic                  flush;
  logic                  stall;
  logic                  busy;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_valid;

  modport master (
    output start, funct3, src_a, src_b, flush,
    input  stall, busy, result, result_valid
  );

  modport slave (
    input  start, funct3, src_a, src_b, flush,
    output stall, busy, result, result_valid
  );
endinterface

// File: rtl/muldiv_core.sv
// Shared shift/add-subtract datapath: one unsigned multiply or restoring-divide step per enable.
// Accumulator holds {hi, lo} product, or {remainder, quotient} during division.
module muldiv_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    step,
  input  logic                    is_div,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic [2*DATA_WIDTH-1:0] acc_nxt
);
  localparam int W = DATA_WIDTH;

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = div_shift - {1'b0, opb_q};

    acc_d = acc_q;
    opb_d = opb_q;
    if (load) begin
      acc_d = {{W{1'b0}}, op_a};
      opb_d = op_b;
    end else if (step) begin
      if (!is_div) begin
        acc_d = {mul_sum, acc_q[W-1:1]};
      end else if (!div_diff[W]) begin
        // trial subtract fits: keep the difference and shift a 1 into the quotient
        acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
      end else begin
        acc_d = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
      end
    end
  end

  assign acc_nxt = acc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M iterative mul/div: DATA_WIDTH+1 stall cycles normally, 1 for divide-by-zero/overflow.
// Stalls the pipeline combinationally; flush aborts with no result.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  md
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     f3_q, f3_d;
  logic           neg_q, neg_d;
  logic           rneg_q, rneg_d;
  logic [W-1:0]   result_q, result_d;

  logic           a_neg, b_neg, div_zero, div_ovf, special;
  logic [W-1:0]   a_mag, b_mag, special_res, final_res;
  logic [W-1:0]   quot_fix, rem_fix;
  logic [2*W-1:0] acc_nxt, prod_fix;
  logic           load, step;

  muldiv_core #(.DATA_WIDTH(W)) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .is_div  (f3_q[2]),
    .op_a    (a_mag),
    .op_b    (b_mag),
    .acc_nxt (acc_nxt)
  );

  // MUL uses unsigned magnitudes: the low half is identical for any signedness
  always_comb begin
    a_neg = md.src_a[W-1] && (md.funct3 == MD_MULH || md.funct3 == MD_MULHSU ||
                              md.funct3 == MD_DIV  || md.funct3 == MD_REM);
    b_neg = md.src_b[W-1] && (md.funct3 == MD_MULH || md.funct3 == MD_DIV ||
                              md.funct3 == MD_REM);
    a_mag = a_neg ? ('0 - md.src_a) : md.src_a;
    b_mag = b_neg ? ('0 - md.src_b) : md.src_b;

    div_zero = md.funct3[2] && (md.src_b == '0);
    div_ovf  = (md.funct3 == MD_DIV || md.funct3 == MD_REM) &&
               (md.src_a == INT_MIN) && (md.src_b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = md.funct3[1] ? md.src_a : '1;
    else          special_res = md.funct3[1] ? '0 : md.src_a;

    prod_fix = neg_q  ? ('0 - acc_nxt) : acc_nxt;
    quot_fix = neg_q  ? ('0 - acc_nxt[W-1:0]) : acc_nxt[W-1:0];
    rem_fix  = rneg_q ? ('0 - acc_nxt[2*W-1:W]) : acc_nxt[2*W-1:W];
    case (f3_q)
      MD_MUL:                        final_res = prod_fix[W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  final_res = prod_fix[2*W-1:W];
      MD_DIV, MD_DIVU:               final_res = quot_fix;
      default:                       final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (md.start) begin
          f3_d   = md.funct3;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (special) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        step  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          result_d = final_res;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (md.flush) begin
      state_d  = IDLE;
      result_d = result_q;
      load     = 1'b0;
      step     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign md.stall        = !md.flush && ((state_q == IDLE && md.start) || state_q == BUSY);
  assign md.busy         = (state_q != IDLE);
  assign md.result_valid = (state_q == DONE) && !md.flush;
  assign md.result       = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: checks results, stall length and valid timing.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_if #(.DATA_WIDTH(32)) md ();

  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one instruction with start held until its result_valid cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input bit keep_start,
                        input string tag);
    int stalls;
    int vcyc;
    logic [31:0] res;
    @(posedge clk); #1;
    md.start  = 1'b1;
    md.funct3 = f3;
    md.src_a  = a;
    md.src_b  = b;
    stalls = 0;
    vcyc   = -1;
    res    = '0;
    for (int cyc = 0; cyc < 100 && vcyc < 0; cyc++) begin
      @(negedge clk);
      if (md.stall) stalls++;
      if (md.result_valid) begin
        vcyc = cyc;
        res  = md.result;
      end else begin
        @(posedge clk); #1;
      end
    end
    check_eq({tag, " result"}, res, exp);
    check_eq({tag, " valid_cycle"}, vcyc, exp_lat);
    check_eq({tag, " stall_cycles"}, stalls, exp_lat);
    if (!keep_start) begin
      @(posedge clk); #1;
      md.start = 1'b0;
      @(negedge clk);
      check_eq({tag, " valid_after"}, {31'd0, md.result_valid}, 32'd0);
      check_eq({tag, " hold"}, md.result, exp);
    end
  endtask

  initial begin
    md.start  = 1'b0;
    md.funct3 = MD_MUL;
    md.src_a  = '0;
    md.src_b  = '0;
    md.flush  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst busy",   {31'd0, md.busy}, 32'd0);
    check_eq("rst valid",  {31'd0, md.result_valid}, 32'd0);
    check_eq("rst result", md.result, 32'd0);
    check_eq("rst stall",  {31'd0, md.stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op(MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0, "mul_7_m3");
    run_op(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0, "mulhu_ff");
    run_op(MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 1'b0, "mulh_ff");
    run_op(MD_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 1'b0, "mulhsu_m1_2");
    run_op(MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0, "div_m7_2");
    run_op(MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0, "rem_m7_2");
    run_op(MD_DIVU,   32'd100,      32'd7,        32'd14,       33, 1'b0, "divu_100_7");
    run_op(MD_REMU,   32'hFFFFFFFF, 32'h10,       32'h0000000F, 33, 1'b0, "remu_ff_16");
    run_op(MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b0, "divu_by0");
    run_op(MD_REM,    32'd5,        32'd0,        32'd5,        1,  1'b0, "rem_by0");
    run_op(MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0, "div_ovf");
    run_op(MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  1'b0, "rem_ovf");

    // Flush on the tenth BUSY cycle: no pulse afterwards, then a clean restart.
    @(posedge clk); #1;
    md.start = 1'b1; md.funct3 = MD_MUL; md.src_a = 32'd9; md.src_b = 32'd9;
    repeat (11) begin @(posedge clk); #1; end
    md.flush = 1'b1;
    @(negedge clk);
    check_eq("flush stall", {31'd0, md.stall}, 32'd0);
    @(posedge clk); #1;
    md.flush = 1'b0;
    md.start = 1'b0;
    @(negedge clk);
    check_eq("flush busy",  {31'd0, md.busy}, 32'd0);
    check_eq("flush stall_after", {31'd0, md.stall}, 32'd0);
    check_eq("flush valid", {31'd0, md.result_valid}, 32'd0);
    @(negedge clk);
    check_eq("flush valid2", {31'd0, md.result_valid}, 32'd0);
    run_op(MD_MUL, 32'd3, 32'd4, 32'd12, 33, 1'b0, "mul_after_flush");

    run_op(MD_MUL, 32'd2, 32'd3, 32'd6,  33, 1'b1, "b2b_first");
    run_op(MD_MUL, 32'd5, 32'd5, 32'd25, 33, 1'b0, "b2b_second");

    // Synchronous reset in the middle of a multiply.
    @(posedge clk); #1;
    md.start = 1'b1; md.funct3 = MD_MUL; md.src_a = 32'd11; md.src_b = 32'd13;
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk);
    check_eq("pre_rst busy", {31'd0, md.busy}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    md.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("midrst busy",   {31'd0, md.busy}, 32'd0);
    check_eq("midrst valid",  {31'd0, md.result_valid}, 32'd0);
    check_eq("midrst result", md.result, 32'd0);
    check_eq("midrst stall",  {31'd0, md.stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(MD_DIVU, 32'd1000, 32'd10, 32'd100, 33, 1'b0, "divu_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit for the RV32M extension, sitting in the EX stage beside the single-cycle ALU.
- Selected when the decoded R-type instruction has Funct7 = 7'b0000001.
- Sequences a shared shift/add-subtract datapath over DATA_WIDTH cycles and drives a stall to freeze IF/ID/EX until the result is ready.
- Result is muxed into the EX/MEM ALU-result path when result_valid = 1.

Parameters:
- DATA_WIDTH, 32: operand and result width. Iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX stage holds a valid M-extension instruction. Held high while the instruction sits stalled in EX.
- funct3  input  3  M operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src_a  input  DATA_WIDTH  rs1 value after forwarding.
- src_b  input  DATA_WIDTH  rs2 value after forwarding.
- flush  input  1  branch/jump flush of EX. Aborts any operation.
- stall  output  1  freeze request to hazard logic (combinational).
- busy  output  1  state != IDLE (registered).
- result  output  DATA_WIDTH  rd value, valid only with result_valid.
- result_valid  output  1  one-cycle pulse; EX instruction may advance.

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset values: state = IDLE, busy = 0, result_valid = 0, result = 0, iteration counter = 0.
- stall = (state == IDLE && start && !flush) || (state == BUSY).
- stall = 0 in DONE.
- IDLE, start = 1, flush = 0:
  - Latch funct3, src_a, src_b.
  - Compute operand magnitudes and the result sign.
  - Normal case: go to BUSY with counter = 0.
- Special divide cases (IDLE goes straight to DONE, total stall 1 cycle):
  - Divide by zero (src_b == 0): DIV/DIVU give all ones; REM/REMU give src_a.
  - Signed overflow (DIV/REM, src_a = 0x80000000, src_b = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- BUSY, multiply: one shift-add step per cycle on an unsigned 2*DATA_WIDTH accumulator.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half.
  - Sign correction is applied when the sign flag is set: MULH treats both operands as signed, MULHSU only src_a, MULHU neither.
- BUSY, divide: one restoring-division step per cycle (shift remainder, trial subtract, set quotient bit).
  - Quotient sign = sign(a) XOR sign(b), signed ops only.
  - Remainder sign = sign(a), signed ops only.
- BUSY exit: when counter == DATA_WIDTH-1, go to DONE and register the final signed result.
- DONE:
  - result_valid = 1, stall = 0; the pipeline advances this cycle.
  - start is ignored in DONE.
  - Unconditionally go to IDLE. A following M instruction starts in IDLE on the next cycle.
- Latency, normal path:
  - Start accepted at cycle 0.
  - stall high for cycles 0..DATA_WIDTH, i.e. 33 cycles at the default width.
  - result_valid at cycle DATA_WIDTH+1.
- flush in any state: next state IDLE, no result_valid, stall = 0 in that cycle. Flush overrides start.
- reset mid-operation: same as flush, plus all registers return to reset values.
- result holds its last value outside DONE; the consumer must qualify it with result_valid.

Decomposition:
- Package muldiv_pkg:
  - funct3 localparams (MD_MUL..MD_REMU) and FUNCT7_MULDIV = 7'b0000001.
  - state_t enum {IDLE, BUSY, DONE}.
- Sub-module muldiv_core: the iteration datapath (accumulator/remainder/quotient registers, one step per enable).
- muldiv_sequencer top: FSM, counter, operand sign/magnitude prep, special-case detection, final sign fix-up.

Test Plan:
- MUL a = 7, b = 0xFFFFFFFD (-3) -> stall high for 33 cycles; result = 0xFFFFFFEB with a one-cycle result_valid at cycle 33.
- MULHU a = b = 0xFFFFFFFF -> result 0xFFFFFFFE. MULH with the same operands -> 0x00000000.
- DIV a = 0xFFFFFFF9 (-7), b = 2 -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). DIVU a = 100, b = 7 -> 14.
- DIVU a = 5, b = 0 -> 0xFFFFFFFF with stall for 1 cycle only. REM a = 5, b = 0 -> 5. DIV a = 0x80000000, b = 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Flush asserted at BUSY cycle 10 -> next cycle IDLE, stall = 0, no result_valid pulse. A new MUL 3*4 started two cycles later -> 12 after the normal latency.
- Back-to-back: start held through DONE for MUL 2*3, with the next instruction MUL 5*5 presented the following cycle -> results 6 then 25, exactly one result_valid pulse each. Synchronous reset mid-BUSY -> all outputs 0 next cycle.
